// File: rtl/hs_src_ctrl.sv
// hs_src_ctrl: source side of a 4-phase req/ack handshake for multi-bit clock-domain crossings.
// A word accepted from a valid/ready producer is held on data_o for the whole transaction while
// req_o is sequenced against an ack_i from the destination domain. ack_i is resynchronized
// through a DEPTH-stage flip-flop chain, and only the synchronized copy drives the FSM.
//
// Ports:
//   clk_i    in   1      clock
//   rst_i    in   1      synchronous, active-high reset
//   valid_i  in   1      producer has a word on data_i
//   data_i   in   WIDTH  word to transfer
//   ready_o  out  1      controller can accept a word (IDLE and not in reset)
//   data_o   out  WIDTH  held word, stable while req_o is high or while releasing
//   req_o    out  1      handshake request to the destination
//   ack_i    in   1      asynchronous acknowledge from the destination
//   done_o   out  1      one-cycle pulse on normal completion
//   err_o    out  1      one-cycle pulse when a transfer is aborted by timeout
module hs_src_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             req_o,
    input  logic             ack_i,
    output logic             done_o,
    output logic             err_o
);

    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = '1;
    // Only meaningful when the timeout is enabled.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0] ack_sync_q;
    logic             ack_s;

    // Bit 0 is the first stage; the FSM only ever sees the last stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[DEPTH-2:0], ack_i};
        end
    end

    assign ack_s = ack_sync_q[DEPTH-1];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abort_d = abort_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                // ack_s is deliberately ignored here: stray acks in IDLE have no effect.
                if (valid_i) begin
                    data_d  = data_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // Ack takes priority over a timeout landing on the same edge.
                if (ack_s) begin
                    req_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = StRel;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                    state_d = StRel;
                end
            end
            StRel: begin
                // Wait for the ack line to drop even after an abort so a late ack is drained.
                if (!ack_s) begin
                    done_d  = ~abort_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        ready_o = (state_q == StIdle) && !rst_i;
    end

    assign data_o = data_q;
    assign req_o  = req_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_hs_src_ctrl.sv
module tb_hs_src_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       req_o;
    logic       ack_i;
    logic       done_o;
    logic       err_o;

    logic       loop_en;
    logic       ack_drv;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    assign ack_i = loop_en ? req_o : ack_drv;

    hs_src_ctrl #(
        .WIDTH   (8),
        .DEPTH   (2),
        .TIMEOUT (8)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .req_o   (req_o),
        .ack_i   (ack_i),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ack;
        logic       ready;
        logic       req;
        logic [7:0] dout;
        logic       done;
        logic       err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] words[4];
    int         acc[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic valid, input logic [7:0] data,
                                input logic ack, input logic ready, input logic req,
                                input logic [7:0] dout, input logic done, input logic err);
        vec_t v;
        v = '{rst, valid, data, ack, ready, req, dout, done, err};
        vecs.push_back(v);
    endfunction

    // Drive one vector at the falling edge, check ready_o before the rising edge and the
    // registered outputs just after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_i);
        rst_i   = v.rst;
        valid_i = v.valid;
        data_i  = v.data;
        ack_drv = v.ack;
        #1;
        check($sformatf("v%0d ready", idx), 32'(ready_o), 32'(v.ready));
        @(posedge clk_i);
        #1;
        check($sformatf("v%0d req", idx),  32'(req_o),  32'(v.req));
        check($sformatf("v%0d data", idx), 32'(data_o), 32'(v.dout));
        check($sformatf("v%0d done", idx), 32'(done_o), 32'(v.done));
        check($sformatf("v%0d err", idx),  32'(err_o),  32'(v.err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dn;
        int er;

        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ack_drv = 1'b0;
        loop_en = 1'b0;
        words   = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset held 3 cycles with valid/ack toggling.
        add(1, 1, 8'hFF, 1, 0, 0, 8'h00, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Timeout with ack stuck low: req high 8 cycles, err with the first low cycle.
        add(0, 1, 8'h3C, 0, 1, 1, 8'h3C, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 8'h00, 0, 0, 1, 8'h3C, 0, 0);
        add(0, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 8'h3C, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 8'h3C, 0, 0);
        // Ack arriving after the controller is back in IDLE is ignored.
        for (int k = 0; k < 3; k++) add(0, 0, 8'h00, 1, 1, 0, 8'h3C, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 0, 8'h00, 0, 1, 0, 8'h3C, 0, 0);
        // Late ack straddling the timeout: abort, then drain in REL with no done.
        add(0, 1, 8'hC3, 0, 1, 1, 8'hC3, 0, 0);
        for (int k = 1; k <= 6; k++) add(0, 0, 8'h00, 0, 0, 1, 8'hC3, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1, 8'hC3, 0, 0);
        add(0, 0, 8'h00, 1, 0, 0, 8'hC3, 0, 1);
        for (int k = 9; k <= 16; k++) add(0, 0, 8'h00, 1, 0, 0, 8'hC3, 0, 0);
        for (int k = 17; k <= 19; k++) add(0, 0, 8'h00, 0, 0, 0, 8'hC3, 0, 0);
        add(0, 0, 8'h00, 0, 1, 0, 8'hC3, 0, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        // Loopback: four back-to-back words, 7 cycles apart, one done each.
        @(negedge clk_i);
        loop_en = 1'b1;
        for (int w = 0; w < 4; w++) begin
            n = 0;
            if (w > 0) @(negedge clk_i);
            while (!ready_o && n < 20) begin
                @(negedge clk_i);
                n++;
            end
            check($sformatf("lb%0d ready", w), 32'(ready_o), 32'd1);
            valid_i = 1'b1;
            data_i  = words[w];
            @(posedge clk_i);
            #1;
            acc[w] = cyc;
            check($sformatf("lb%0d req", w),  32'(req_o),  32'd1);
            check($sformatf("lb%0d data", w), 32'(data_o), 32'(words[w]));
            @(negedge clk_i);
            valid_i = 1'b0;
            data_i  = ~words[w];
            dn = 0;
            er = 0;
            repeat (6) begin
                @(posedge clk_i);
                #1;
                if (req_o) check($sformatf("lb%0d hold", w), 32'(data_o), 32'(words[w]));
                if (done_o) dn++;
                if (err_o) er++;
            end
            check($sformatf("lb%0d done count", w), 32'(dn), 32'd1);
            check($sformatf("lb%0d err count", w),  32'(er), 32'd0);
            if (w > 0) check($sformatf("lb%0d period", w), 32'(acc[w] - acc[w-1]), 32'd7);
        end
        @(negedge clk_i);
        loop_en = 1'b0;

        // Ack reaches ack_s on the same edge the counter hits TIMEOUT-1: ack wins.
        valid_i = 1'b1;
        data_i  = 8'h5C;
        @(posedge clk_i);
        #1;
        check("sim req E0", 32'(req_o), 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        ack_drv = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("sim req E7", 32'(req_o), 32'd1);
        @(posedge clk_i);
        #1;
        check("sim req E8", 32'(req_o), 32'd0);
        check("sim err E8", 32'(err_o), 32'd0);
        @(negedge clk_i);
        ack_drv = 1'b0;
        dn = 0;
        er = 0;
        repeat (10) begin
            @(posedge clk_i);
            #1;
            if (done_o) dn++;
            if (err_o) er++;
        end
        check("sim done count", 32'(dn), 32'd1);
        check("sim err count",  32'(er), 32'd0);

        // Reset in the middle of REQ drops the transfer silently.
        @(negedge clk_i);
        valid_i = 1'b1;
        data_i  = 8'hA5;
        @(posedge clk_i);
        #1;
        check("rst req", 32'(req_o), 32'd1);
        check("rst data", 32'(data_o), 32'hA5);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("rst ready low", 32'(ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        check("rst req cleared", 32'(req_o), 32'd0);
        check("rst data cleared", 32'(data_o), 32'h00);
        check("rst done", 32'(done_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst ready after", 32'(ready_o), 32'd1);
        valid_i = 1'b1;
        data_i  = 8'h96;
        loop_en = 1'b1;
        @(posedge clk_i);
        #1;
        check("post-rst req", 32'(req_o), 32'd1);
        check("post-rst data", 32'(data_o), 32'h96);
        @(negedge clk_i);
        valid_i = 1'b0;
        dn = 0;
        er = 0;
        repeat (8) begin
            @(posedge clk_i);
            #1;
            if (done_o) dn++;
            if (err_o) er++;
        end
        check("post-rst done count", 32'(dn), 32'd1);
        check("post-rst err count", 32'(er), 32'd0);
        check("post-rst data held", 32'(data_o), 32'h96);
        loop_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
